// File: rtl/neokeon_pi1_rotl_stream.sv
// Word-serial Neokeon Pi1 stage: rotates each of the four state words left by
// its per-word amount and presents it through a one-deep valid/ready register.
module neokeon_pi1_rotl_stream #(
  parameter int ROT_W0 = 0,
  parameter int ROT_W1 = 1,
  parameter int ROT_W2 = 5,
  parameter int ROT_W3 = 2
) (
  input  logic        inClk,
  input  logic        inRst,
  input  logic        inValid,
  output logic        outReadyUp,
  input  logic [31:0] inDataWord,
  input  logic        inAbort,
  output logic        outValid,
  input  logic        inReady,
  output logic [31:0] outputData,
  output logic [1:0]  outWordIdx,
  output logic        outLast,
  output logic [7:0]  outFrameCnt
);

  localparam logic [4:0] AMT0 = 5'(ROT_W0 % 32);
  localparam logic [4:0] AMT1 = 5'(ROT_W1 % 32);
  localparam logic [4:0] AMT2 = 5'(ROT_W2 % 32);
  localparam logic [4:0] AMT3 = 5'(ROT_W3 % 32);

  logic [1:0]  wrIdx;
  logic [4:0]  rotAmt;
  logic [63:0] rotDouble;
  logic [31:0] rotWord;
  logic        accept;
  logic        outHandshake;

  always_comb begin
    rotAmt = AMT0;
    case (wrIdx)
      2'd0:    rotAmt = AMT0;
      2'd1:    rotAmt = AMT1;
      2'd2:    rotAmt = AMT2;
      default: rotAmt = AMT3;
    endcase
  end

  // Shifting the doubled word left and keeping the top half yields a rotate-left,
  // and an amount of zero passes the word through unchanged.
  assign rotDouble = {inDataWord, inDataWord} << rotAmt;
  assign rotWord   = rotDouble[63:32];

  assign outReadyUp   = !outValid || inReady;
  assign accept       = inValid && outReadyUp;
  assign outHandshake = outValid && inReady;
  assign outLast      = outValid && (outWordIdx == 2'd3);

  // Abort drops both the partial input frame and any word still waiting downstream.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      wrIdx       <= 2'd0;
      outValid    <= 1'b0;
      outputData  <= 32'd0;
      outWordIdx  <= 2'd0;
      outFrameCnt <= 8'd0;
    end else if (inAbort) begin
      wrIdx    <= 2'd0;
      outValid <= 1'b0;
    end else begin
      if (outHandshake && (outWordIdx == 2'd3)) begin
        outFrameCnt <= outFrameCnt + 8'd1;
      end
      if (accept) begin
        outputData <= rotWord;
        outWordIdx <= wrIdx;
        outValid   <= 1'b1;
        wrIdx      <= wrIdx + 2'd1;
      end else if (outHandshake) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neokeon_pi1_rotl_stream.sv
// Self-checking bench for neokeon_pi1_rotl_stream: directed scenarios plus random
// frames scored against a transaction-level queue model of the stage.
module tb_neokeon_pi1_rotl_stream;

  logic        clk = 1'b0;
  logic        inRst, inValid, inAbort, inReady;
  logic [31:0] inDataWord;
  logic        outReadyUp, outValid, outLast;
  logic [31:0] outputData;
  logic [1:0]  outWordIdx;
  logic [7:0]  outFrameCnt;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] expData[$];
  logic [1:0]  expIdx[$];
  int          modelWr;
  logic [7:0]  modelCnt;
  int          framesDone;
  int          rotAmt[4] = '{0, 1, 5, 2};

  always #5 clk = ~clk;

  neokeon_pi1_rotl_stream dut (
    .inClk      (clk),
    .inRst      (inRst),
    .inValid    (inValid),
    .outReadyUp (outReadyUp),
    .inDataWord (inDataWord),
    .inAbort    (inAbort),
    .outValid   (outValid),
    .inReady    (inReady),
    .outputData (outputData),
    .outWordIdx (outWordIdx),
    .outLast    (outLast),
    .outFrameCnt(outFrameCnt)
  );

  function automatic logic [31:0] refRotl(input logic [31:0] x, input int n);
    logic [63:0] v;
    int          m;
    v = {32'd0, x};
    m = n % 32;
    return 32'((v << m) | (v >> (32 - m)));
  endfunction

  function automatic logic [31:0] refRotr(input logic [31:0] x, input int n);
    return refRotl(x, (32 - (n % 32)) % 32);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check against the model, then advance the model at posedge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy, input logic abt);
    logic expValid, expReady, hs, acc;
    @(negedge clk);
    inValid = v; inDataWord = d; inReady = rdy; inAbort = abt; inRst = 1'b0;
    #1;
    expValid = (expData.size() > 0);
    expReady = !expValid || rdy;
    checkOutput("outValid", 32'(outValid), 32'(expValid));
    checkOutput("outReadyUp", 32'(outReadyUp), 32'(expReady));
    checkOutput("outFrameCnt", 32'(outFrameCnt), 32'(modelCnt));
    if (expValid) begin
      checkOutput("outputData", outputData, expData[0]);
      checkOutput("outWordIdx", 32'(outWordIdx), 32'(expIdx[0]));
      checkOutput("outLast", 32'(outLast), 32'(expIdx[0] == 2'd3));
    end else begin
      checkOutput("outLast_idle", 32'(outLast), 32'd0);
    end
    @(posedge clk);
    if (abt) begin
      expData.delete();
      expIdx.delete();
      modelWr = 0;
    end else begin
      hs  = expValid && rdy;
      acc = v && expReady;
      if (hs) begin
        if (expIdx[0] == 2'd3) begin
          modelCnt++;
          framesDone++;
        end
        void'(expData.pop_front());
        void'(expIdx.pop_front());
      end
      if (acc) begin
        expData.push_back(refRotl(d, rotAmt[modelWr]));
        expIdx.push_back(2'(modelWr));
        modelWr = (modelWr + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic doReset(input int cycles, input logic rdy);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      inRst = 1'b1; inValid = 1'b0; inAbort = 1'b0; inReady = rdy;
    end
    @(posedge clk);
    #1;
    expData.delete();
    expIdx.delete();
    modelWr  = 0;
    modelCnt = 8'd0;
    @(negedge clk);
    inRst = 1'b0;
  endtask

  initial begin
    logic [31:0] w3Seen;
    int          cycles;
    inRst = 1'b1; inValid = 1'b0; inAbort = 1'b0; inReady = 1'b1; inDataWord = 32'd0;
    modelWr = 0; modelCnt = 8'd0; framesDone = 0; w3Seen = 32'd0;

    // Reset then idle
    doReset(2, 1'b1);
    checkOutput("rst_outValid", 32'(outValid), 32'd0);
    checkOutput("rst_outputData", outputData, 32'd0);
    checkOutput("rst_outFrameCnt", 32'(outFrameCnt), 32'd0);
    checkOutput("rst_outReadyUp", 32'(outReadyUp), 32'd1);

    // Single frame of identical words with constant expectations
    applyStimulus(1'b1, 32'h1111aaaa, 1'b1, 1'b0);
    checkOutput("frame_w0", outputData, 32'h1111aaaa);
    applyStimulus(1'b1, 32'h1111aaaa, 1'b1, 1'b0);
    checkOutput("frame_w1", outputData, 32'h22235554);
    checkOutput("frame_idx1", 32'(outWordIdx), 32'd1);
    applyStimulus(1'b1, 32'h1111aaaa, 1'b1, 1'b0);
    checkOutput("frame_w2", outputData, 32'h22355542);
    applyStimulus(1'b1, 32'h1111aaaa, 1'b1, 1'b0);
    checkOutput("frame_w3", outputData, 32'h4446aaa8);
    checkOutput("frame_last", 32'(outLast), 32'd1);
    w3Seen = outputData;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("frame_cnt", 32'(outFrameCnt), 32'd1);
    checkOutput("roundtrip_rotr2", refRotr(w3Seen, 2), 32'h1111aaaa);

    // Backpressure holds the first word and stalls upstream
    doReset(1, 1'b1);
    applyStimulus(1'b1, 32'h1111aaaa, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h1111aaaa, 1'b0, 1'b0);
    checkOutput("bp_valid", 32'(outValid), 32'd1);
    checkOutput("bp_data", outputData, 32'h1111aaaa);
    checkOutput("bp_ready", 32'(outReadyUp), 32'd0);
    applyStimulus(1'b1, 32'h1111aaaa, 1'b1, 1'b0);
    checkOutput("bp_release_data", outputData, 32'h22235554);
    checkOutput("bp_release_idx", 32'(outWordIdx), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

    // Abort mid-frame restarts word numbering
    doReset(1, 1'b1);
    applyStimulus(1'b1, 32'h01234567, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h89abcdef, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hdeadbeef, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h80000001, 1'b1, 1'b0);
    checkOutput("abort_idx0", 32'(outWordIdx), 32'd0);
    checkOutput("abort_w0", outputData, 32'h80000001);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h80000001, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("abort_cnt", 32'(outFrameCnt), 32'd1);

    // Reset mid-frame while stalled
    applyStimulus(1'b1, 32'h00000003, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00000003, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00000003, 1'b0, 1'b0);
    doReset(1, 1'b0);
    checkOutput("midrst_valid", 32'(outValid), 32'd0);
    checkOutput("midrst_cnt", 32'(outFrameCnt), 32'd0);
    applyStimulus(1'b1, 32'h00000003, 1'b1, 1'b0);
    checkOutput("midrst_idx0", 32'(outWordIdx), 32'd0);
    checkOutput("midrst_w0", outputData, 32'h00000003);

    // Random traffic until 1000 frames complete
    doReset(1, 1'b1);
    framesDone = 0;
    cycles = 0;
    while (framesDone < 1000 && cycles < 60000) begin
      applyStimulus(($urandom_range(0, 99) < 80), $urandom, ($urandom_range(0, 99) < 75),
                    ($urandom_range(0, 999) < 5));
      cycles++;
    end
    checkOutput("random_frames_done", 32'(framesDone >= 1000), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/neokeon_pi1_rotl_stream.md
Name: neokeon_pi1_rotl_stream

Overview:
- Word-serial Neokeon Pi1 stage. Each 128-bit state arrives as four 32-bit words, word 0 first.
- Each word is rotated LEFT by its per-word Pi1 amount. This is the inverse direction of the existing ROTR-by-2/Pi2 logic.
- Output passes through a registered valid/ready stage with frame tracking.
- Sits between the Theta and Gamma word-stream stages of the iterative round datapath.

Parameters:
- ROT_W0, 0, rotate-left amount for word 0 (range 0..31)
- ROT_W1, 1, rotate-left amount for word 1
- ROT_W2, 5, rotate-left amount for word 2
- ROT_W3, 2, rotate-left amount for word 3

Ports:
- inClk  input  1  clock; all logic on rising edge
- inRst  input  1  synchronous reset, active-high
- inValid  input  1  upstream word valid
- outReadyUp  output  1  ready to upstream
- inDataWord  input  32  upstream data word
- inAbort  input  1  synchronous frame abort; discards the partial frame
- outValid  output  1  downstream word valid
- inReady  input  1  downstream ready
- outputData  output  32  rotated word
- outWordIdx  output  2  index (0..3) of the word on outputData
- outLast  output  1  high when outWordIdx==3 and outValid
- outFrameCnt  output  8  completed output frames; wraps 255->0

Behaviour:
- Reset (inRst=1 at a clock edge):
  - outValid=0, outputData=0, outWordIdx=0, outLast=0, outFrameCnt=0.
  - Input word counter wrIdx=0.
  - Reset overrides everything, including mid-frame. The partial frame is lost.
- outReadyUp = !outValid || inReady (combinational).
- accept = inValid && outReadyUp.
- On accept:
  - outputData <= ROTL(inDataWord, ROT_Wk), where k=wrIdx. Rotation is mod 32; amount 0 passes the word through.
  - outWordIdx <= wrIdx; outValid <= 1; wrIdx <= wrIdx+1 (2-bit wrap 3->0).
- Latency: one cycle from accept to outValid. Throughput is one word per cycle while inReady=1.
- Backpressure: if outValid && !inReady, then outputData, outWordIdx and outValid hold, and outReadyUp=0.
- If outValid && inReady && !accept, outValid <= 0 next cycle. outputData keeps its last value.
- Simultaneous output handshake and accept: a new word replaces the old one with no bubble.
- outFrameCnt increments on each output handshake (outValid && inReady) where outWordIdx==3.
- inAbort (priority below inRst, above accept):
  - wrIdx <= 0; outValid <= 0; the same-cycle input word is not accepted.
  - outFrameCnt is unchanged.
  - outReadyUp still follows its formula. Upstream must treat an abort-cycle handshake as dropped.
- Data is never reordered. The word index is derived only from the accept count since reset/abort.
- No X propagation: outputData is defined at all times after reset.

Test Plan:
- Reset then idle: hold inRst 2 cycles -> outValid=0, outputData=0, outFrameCnt=0, outReadyUp=1.
- Single frame, inReady=1, words 0x1111aaaa x4 -> outputs 0x1111aaaa, 0x22235554, 0x22355542, 0x4446aaa8. Indices 0..3, outLast on the 4th, outFrameCnt=1, each output 1 cycle after accept.
- Backpressure: inReady=0 after first accept, inValid held with word1 -> outValid stays 1, outputData=0x1111aaaa holds, outReadyUp=0. Release inReady -> word1 appears next cycle with outWordIdx=1.
- Abort mid-frame: accept 2 words, assert inAbort 1 cycle, then send 4 new words -> new outputs start at outWordIdx=0, outFrameCnt counts only the full frame.
- Round trip: feed word3 output 0x4446aaa8 to the ROTR-by-2 function -> 0x1111aaaa. Repeat with 1000 random frames against a reference model; all words match.
- Reset mid-frame with outValid=1 and inReady=0 -> next cycle outValid=0, wrIdx=0, outFrameCnt=0.
